// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO behind the peripheral bus
module uart_rx #(
    parameter int CLKFREQ    = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic        wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        uart_rx_i
);
    localparam logic [15:0] BAUD_DIV = 16'(CLKFREQ / BAUD_RATE);
    localparam logic [15:0] HALF_DIV = BAUD_DIV / 16'd2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state, w_next;
    logic        r_sync1, r_sync2, r_prev;
    logic [15:0] r_tcnt;
    logic [2:0]  r_bcnt;
    logic [7:0]  r_shr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_cnt;
    logic        r_ovr, r_ferr;

    logic w_fall, w_half, w_baud, w_stop_smp, w_valid, w_full;
    logic w_rd, w_pop, w_good, w_push, w_ovr_set, w_ferr_set, w_wst, w_unused;

    assign w_fall     = r_prev & ~r_sync2;
    assign w_half     = r_tcnt == HALF_DIV - 16'd1;
    assign w_baud     = r_tcnt == BAUD_DIV - 16'd1;
    assign w_stop_smp = (r_state == S_STOP) & w_baud;
    assign w_valid    = r_cnt != '0;
    assign w_full     = r_cnt == FULL_CNT;
    assign w_rd       = sel_i & ~wen_i & (addr_i[3:0] == 4'h0);
    assign w_wst      = sel_i & wen_i & (addr_i[3:0] == 4'h4);
    assign w_pop      = w_rd & w_valid;
    assign w_good     = w_stop_smp & r_sync2;
    assign w_push     = w_good & (~w_full | w_pop);
    assign w_ovr_set  = w_good & w_full & ~w_pop;
    assign w_ferr_set = w_stop_smp & ~r_sync2;
    assign w_unused   = ^{addr_i[31:4], data_i[31:4], data_i[1:0]};

    // Synchronize the serial line and keep its previous value for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: start on a falling edge, reject glitches at mid start bit
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = w_fall ? S_START : S_IDLE;
            S_START: w_next = w_half ? (r_sync2 ? S_IDLE : S_DATA) : S_START;
            S_DATA:  w_next = (w_baud && r_bcnt == 3'd7) ? S_STOP : S_DATA;
            S_STOP:  w_next = w_baud ? S_IDLE : S_STOP;
        endcase
    end

    // Baud/bit counters and LSB-first shift register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tcnt <= '0;
            r_bcnt <= '0;
            r_shr  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    r_bcnt <= '0;
                end
                S_START: r_tcnt <= w_half ? 16'd0 : r_tcnt + 16'd1;
                S_DATA: begin
                    r_tcnt <= w_baud ? 16'd0 : r_tcnt + 16'd1;
                    if (w_baud) begin
                        r_bcnt <= r_bcnt + 3'd1;
                        r_shr  <= {r_sync2, r_shr[7:1]};
                    end
                end
                S_STOP: r_tcnt <= w_baud ? 16'd0 : r_tcnt + 16'd1;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky error flags (set beats clear)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_cnt  <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            r_ovr  <= w_ovr_set  ? 1'b1 : (w_wst & data_i[2]) ? 1'b0 : r_ovr;
            r_ferr <= w_ferr_set ? 1'b1 : (w_wst & data_i[3]) ? 1'b0 : r_ferr;
        end
    end

    // FIFO storage; contents are only visible while count is non-zero
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= r_shr;
    end

    // Combinational register read mux
    always_comb begin
        data_o = '0;
        if (sel_i && addr_i[3:0] == 4'h0) data_o = w_valid ? {24'b0, r_mem[r_rptr]} : 32'd0;
        if (sel_i && addr_i[3:0] == 4'h4) data_o = {28'b0, r_ferr, r_ovr, w_full, w_valid};
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx and checks bus reads against a queue model
module tb_uart_rx;
    localparam int CLKFREQ = 3_200_000;
    localparam int BAUD    = 100_000;
    localparam int DEPTH   = 4;
    localparam int BIT     = CLKFREQ / BAUD;

    logic        clk = 1'b0;
    logic        rst, sel, wen, rx;
    logic [31:0] addr, wdata, rdata;

    uart_rx #(.CLKFREQ(CLKFREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .wen_i(wen), .addr_i(addr),
        .data_i(wdata), .data_o(rdata), .uart_rx_i(rx)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] q[$];
    bit   m_ovr, m_ferr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [3:0] s;
        s = {m_ferr, m_ovr, q.size() == DEPTH, q.size() != 0};
        return {28'b0, s};
    endfunction

    task automatic send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (!stop_ok) m_ferr = 1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; wen = 1'b0; addr = {28'b0, a};
        #1 d = rdata;
        @(negedge clk);
        sel = 1'b0; addr = '0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d, e;
        e = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'd0;
        rd(4'h0, d);
        check(tag, d, e);
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] d;
        rd(4'h4, d);
        check(tag, d, exp_status());
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        sel = 1'b1; wen = 1'b1; addr = {28'b0, a}; wdata = v;
        @(negedge clk);
        sel = 1'b0; wen = 1'b0; addr = '0;
        if (a == 4'h4) begin
            if (v[2]) m_ovr = 0;
            if (v[3]) m_ferr = 0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 0;
        m_ferr = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  pat;
        rst = 1'b1; rx = 1'b1; sel = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_status("reset_status");
        rd_data("reset_rxdata");

        send(8'hA5, 1); send(8'h3C, 1);
        rd_status("two_bytes_status");
        rd_data("rx_a5"); rd_data("rx_3c");
        rd_status("drained_status");
        rd_data("empty_read");

        for (int i = 1; i <= 5; i++) send(8'(i), 1);
        rd_status("overrun_status");
        sel = 1'b0; addr = 32'h4;
        #1 check("sel_low_zero", rdata, 32'd0);
        rd(4'h8, d);
        check("bad_addr_zero", d, 32'd0);
        wr(4'h0, 32'hFF);
        for (int i = 0; i < 4; i++) rd_data("ovr_fifo_read");
        rd_status("ovr_still_set");
        wr(4'h4, 32'h4);
        rd_status("ovr_cleared");

        send(8'h55, 0);
        rd_status("frame_err_set");
        wr(4'h4, 32'h8);
        rd_status("frame_err_cleared");

        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (BIT * 11) @(negedge clk);
        rd_status("glitch_status");

        send(8'h00, 1); send(8'hFF, 1); send(8'h5A, 1);
        rd_data("rx_00"); rd_data("rx_ff"); rd_data("rx_5a");

        pat = 8'hF0;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            repeat (BIT) @(negedge clk);
        end
        rx = pat[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rd_status("midframe_reset_status");
        send(8'h81, 1);
        rd_data("rx_81_after_reset");

        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            send(b, $urandom_range(0, 7) != 0);
            for (int r = $urandom_range(0, 2); r > 0; r--) rd_data("rand_rxdata");
            if ($urandom_range(0, 3) == 0) wr(4'h4, $urandom);
            rd_status("rand_status");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
